// File: rtl/cic_interp_ctrl.sv
// Sequencer for a multi-stage CIC interpolator: input-rate comb strobe, output-rate
// integrator enable, upstream sample pull with zero-stuff on underrun, fill/flush/clear.
module cic_interp_ctrl #(
  parameter int ISZ        = 16,
  parameter int RATIO_W    = 6,
  parameter int NUM_STAGES = 4,
  parameter int UCNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [RATIO_W-1:0] ratio,
  input  logic [ISZ-1:0]     s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [ISZ-1:0]     cic_in,
  output logic               cic_in_stb,
  output logic               cic_out_stb,
  output logic               cic_clr,
  output logic               out_valid,
  output logic               busy,
  output logic               underrun,
  output logic [UCNT_W-1:0]  underrun_cnt
);

  localparam int CNT_W = $clog2(NUM_STAGES + 3);
  localparam logic [CNT_W-1:0]   STB_LAST  = CNT_W'(NUM_STAGES + 1);
  localparam logic [CNT_W-1:0]   STB_DONE  = CNT_W'(NUM_STAGES + 2);
  localparam logic [RATIO_W-1:0] RATIO_MIN = RATIO_W'(2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t              state, state_d;
  logic [RATIO_W-1:0]  phase, phase_d;
  logic [RATIO_W-1:0]  ratio_q, ratio_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [ISZ-1:0]      cic_in_d;
  logic                out_valid_d;
  logic                underrun_d;
  logic [UCNT_W-1:0]   ucnt_d;
  logic                phase_last;
  logic                feeding;

  assign busy        = (state != IDLE);
  assign cic_in_stb  = busy && (phase == '0);
  assign cic_out_stb = busy;
  assign feeding     = (state == FILL) || (state == RUN);
  assign s_ready     = cic_in_stb && feeding;
  assign phase_last  = (phase == ratio_q - RATIO_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      phase        <= '0;
      ratio_q      <= RATIO_MIN;
      cnt          <= '0;
      cic_in       <= '0;
      out_valid    <= 1'b0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      state        <= state_d;
      phase        <= phase_d;
      ratio_q      <= ratio_d;
      cnt          <= cnt_d;
      cic_in       <= cic_in_d;
      out_valid    <= out_valid_d;
      underrun     <= underrun_d;
      underrun_cnt <= ucnt_d;
    end
  end

  always_comb begin
    state_d     = state;
    phase_d     = busy ? (phase_last ? '0 : phase + RATIO_W'(1)) : '0;
    ratio_d     = ratio_q;
    cnt_d       = cnt;
    cic_in_d    = cic_in;
    out_valid_d = out_valid;
    underrun_d  = 1'b0;
    ucnt_d      = underrun_cnt;
    cic_clr     = 1'b0;

    if (s_ready) begin
      if (s_valid) begin
        cic_in_d = s_data;
      end else begin
        cic_in_d   = '0;
        underrun_d = 1'b1;
        if (underrun_cnt != '1) ucnt_d = underrun_cnt + UCNT_W'(1);
      end
    end else if (cic_in_stb) begin
      cic_in_d = '0;
    end

    case (state)
      IDLE: begin
        if (enable) begin
          state_d = FILL;
          // gated so every output reads 0 while reset is held
          cic_clr = reset;
          ratio_d = (ratio < RATIO_MIN) ? RATIO_MIN : ratio;
          cnt_d   = '0;
        end
      end
      FILL: begin
        if (cic_in_stb) begin
          cnt_d = cnt + CNT_W'(1);
          if (cnt == STB_LAST) begin
            state_d     = RUN;
            cnt_d       = '0;
            out_valid_d = 1'b1;
          end
        end else if (!enable && phase_last) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (!enable && phase_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (cnt == STB_DONE) begin
          state_d = IDLE;
          phase_d = '0;
          cnt_d   = '0;
          cic_clr = 1'b1;
        end else if (cic_in_stb) begin
          cnt_d = cnt + CNT_W'(1);
          // drop out_valid on the last zero strobe so it is already low in the clear cycle
          if (cnt == STB_LAST) out_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cic_interp_ctrl.sv
// Self-checking bench for cic_interp_ctrl: per-scenario tasks plus a cic_in scoreboard.
module tb_cic_interp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [5:0]  ratio;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] cic_in;
  logic        cic_in_stb;
  logic        cic_out_stb;
  logic        cic_clr;
  logic        out_valid;
  logic        busy;
  logic        underrun;
  logic [7:0]  underrun_cnt;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  typedef struct {
    int unsigned due;
    logic [15:0] val;
  } exp_t;
  exp_t sbq[$];

  // flag order: stb, rdy, clr, ov, busy, outstb, und
  logic [6:0] flags;
  assign flags = {cic_in_stb, s_ready, cic_clr, out_valid, busy, cic_out_stb, underrun};

  cic_interp_ctrl #(
    .ISZ(16),
    .RATIO_W(6),
    .NUM_STAGES(4),
    .UCNT_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .ratio(ratio),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .cic_in(cic_in),
    .cic_in_stb(cic_in_stb),
    .cic_out_stb(cic_out_stb),
    .cic_clr(cic_clr),
    .out_valid(out_valid),
    .busy(busy),
    .underrun(underrun),
    .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // cic_in must carry each queued sample one cycle after its strobe
  always @(negedge clk) begin : sb_mon
    exp_t e;
    #2;
    while (sbq.size() != 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      checks++;
      if (cic_in !== e.val) begin
        errors++;
        $display("FAIL cic_in cyc=%0d got %h exp %h", cyc, cic_in, e.val);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = '0; ratio = 6'd4;
    sbq.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; s_valid = 1'b1; s_data = 16'hffff; ratio = 6'd4;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({flags, cic_in, underrun_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got flags=%b cic_in=%h ucnt=%0d exp all 0", flags, cic_in, underrun_cnt);
    end
    @(negedge clk);
    enable = 1'b0; reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); #1;
      checks++;
      if (flags !== 7'b0) begin
        errors++;
        $display("FAIL idle_hold t=%0d got %b exp 0000000", t, flags);
      end
    end
  endtask

  task automatic test_fill();
    logic [6:0] exp;
    logic       stb;
    do_reset();
    for (int t = 0; t <= 30; t++) begin
      @(negedge clk);
      enable = 1'b1; ratio = 6'd4; s_valid = 1'b1; s_data = 16'h1000 + 16'(t);
      #1;
      stb = (t >= 1) && ((t - 1) % 4 == 0);
      exp = {stb, stb, t == 0, t >= 22, t >= 1, t >= 1, 1'b0};
      checks++;
      if (flags !== exp) begin
        errors++;
        $display("FAIL fill t=%0d flags got %b exp %b", t, flags, exp);
      end
      if (stb) sbq.push_back('{cyc + 1, s_data});
    end
  endtask

  task automatic test_underrun();
    logic [6:0] exp;
    logic       stb;
    int         ucnt;
    do_reset();
    for (int t = 0; t <= 40; t++) begin
      @(negedge clk);
      enable = 1'b1; ratio = 6'd4;
      s_valid = !(t == 25 || t == 29 || t == 33);
      s_data = 16'($urandom);
      #1;
      stb  = (t >= 1) && ((t - 1) % 4 == 0);
      ucnt = (t >= 34) ? 3 : (t >= 30) ? 2 : (t >= 26) ? 1 : 0;
      exp  = {stb, stb, t == 0, t >= 22, t >= 1, t >= 1, (t == 26 || t == 30 || t == 34)};
      checks++;
      if (flags !== exp) begin
        errors++;
        $display("FAIL underrun t=%0d flags got %b exp %b", t, flags, exp);
      end
      checks++;
      if (underrun_cnt !== 8'(ucnt)) begin
        errors++;
        $display("FAIL underrun_cnt t=%0d got %0d exp %0d", t, underrun_cnt, ucnt);
      end
      if (stb) sbq.push_back('{cyc + 1, s_valid ? s_data : 16'h0});
    end
  endtask

  task automatic test_flush();
    logic [6:0] exp;
    logic       stb, bsy;
    do_reset();
    for (int t = 0; t <= 100; t++) begin
      @(negedge clk);
      enable = (t < 52) || (t >= 70); ratio = 6'd8; s_valid = 1'b1; s_data = 16'h2000 + 16'(t);
      #1;
      stb = ((t >= 1) && (t <= 97) && ((t - 1) % 8 == 0)) || (t == 100);
      bsy = ((t >= 1) && (t <= 98)) || (t >= 100);
      exp = {stb, stb && (t < 57 || t == 100), (t == 0 || t == 98 || t == 99),
             (t >= 42 && t <= 97), bsy, bsy, 1'b0};
      checks++;
      if (flags !== exp) begin
        errors++;
        $display("FAIL flush t=%0d flags got %b exp %b", t, flags, exp);
      end
      if (stb && t <= 97) sbq.push_back('{cyc + 1, (t < 57) ? s_data : 16'h0});
    end
    checks++;
    if (underrun_cnt !== 8'd0) begin
      errors++;
      $display("FAIL flush_ucnt got %0d exp 0", underrun_cnt);
    end
  endtask

  task automatic test_ratio_clamp();
    logic [6:0] exp;
    logic       stb;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int t = 0; t <= 30; t++) begin
        @(negedge clk);
        enable = 1'b1; ratio = (t < 14) ? 6'(r) : 6'd10; s_valid = 1'b1; s_data = 16'h3000 + 16'(t);
        #1;
        stb = (t % 2 == 1);
        exp = {stb, stb, t == 0, t >= 12, t >= 1, t >= 1, 1'b0};
        checks++;
        if (flags !== exp) begin
          errors++;
          $display("FAIL clamp r=%0d t=%0d flags got %b exp %b", r, t, flags, exp);
        end
        if (stb) sbq.push_back('{cyc + 1, s_data});
      end
    end
  endtask

  task automatic test_saturation();
    logic [6:0] exp;
    logic       stb;
    int         ucnt;
    do_reset();
    for (int t = 0; t <= 610; t++) begin
      @(negedge clk);
      enable = 1'b1; ratio = 6'd2; s_valid = 1'b0; s_data = 16'hbeef;
      #1;
      stb  = (t % 2 == 1);
      ucnt = (t / 2 > 255) ? 255 : t / 2;
      exp  = {stb, stb, t == 0, t >= 12, t >= 1, t >= 1, (t >= 2) && (t % 2 == 0)};
      checks++;
      if (flags !== exp) begin
        errors++;
        $display("FAIL sat t=%0d flags got %b exp %b", t, flags, exp);
      end
      checks++;
      if (underrun_cnt !== 8'(ucnt)) begin
        errors++;
        $display("FAIL sat_cnt t=%0d got %0d exp %0d", t, underrun_cnt, ucnt);
      end
      if (stb) sbq.push_back('{cyc + 1, 16'h0});
    end
  endtask

  task automatic test_reset_midop();
    int last;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      last = (m == 0) ? 30 : 33;
      for (int t = 0; t <= last; t++) begin
        @(negedge clk);
        enable = (m == 0) || (t < 25); ratio = 6'd4; s_valid = 1'b0; s_data = 16'hdead;
        #1;
        if (t == last) begin
          checks++;
          if (underrun_cnt !== ((m == 0) ? 8'd8 : 8'd7)) begin
            errors++;
            $display("FAIL midop_ucnt m=%0d got %0d exp %0d", m, underrun_cnt, (m == 0) ? 8 : 7);
          end
          if (m == 1) begin
            checks++;
            if (flags !== 7'b1001110) begin
              errors++;
              $display("FAIL midflush_state got %b exp 1001110", flags);
            end
          end
        end
      end
      @(negedge clk);
      enable = 1'b1;
      #1;
      reset = 1'b0;
      sbq.delete();
      #1;
      checks++;
      if ({flags, cic_in, underrun_cnt} !== '0) begin
        errors++;
        $display("FAIL midop_async m=%0d got flags=%b cic_in=%h ucnt=%0d exp all 0", m, flags, cic_in, underrun_cnt);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (flags !== 7'b0010000) begin
        errors++;
        $display("FAIL restart_clr m=%0d got %b exp 0010000", m, flags);
      end
      @(negedge clk); #1;
      checks++;
      if (flags !== 7'b1100110) begin
        errors++;
        $display("FAIL restart_stb m=%0d got %b exp 1100110", m, flags);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_underrun();
    test_flush();
    test_ratio_clamp();
    test_saturation();
    test_reset_midop();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_interp_ctrl.md
Name: cic_interp_ctrl

Overview:
Single-clock sequencer for the 4-stage CIC interpolator datapath. It generates the input-rate comb strobe and output-rate integrator enable from a programmable ratio. It pulls samples from an upstream valid/ready stream and zero-stuffs on underrun. It also manages start, pipeline fill, flush-on-stop and datapath clear, so the CIC never sees stale or half-drained state.

Parameters:
ISZ, 16, sample width (matches CIC input word)
RATIO_W, 6, width of ratio port; legal ratio 2..2^RATIO_W-1
NUM_STAGES, 4, CIC stage count; sets fill/flush length
UCNT_W, 8, underrun counter width

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  level; 1 = run interpolator, 0 = stop (with flush)
ratio  in  RATIO_W  interpolation ratio; sampled only on IDLE->FILL
s_data  in  ISZ  upstream sample
s_valid  in  1  upstream sample valid
s_ready  out  1  sample accepted this cycle when s_valid&s_ready
cic_in  out  ISZ  registered sample to CIC comb input
cic_in_stb  out  1  comb-section enable, one cycle per input period
cic_out_stb  out  1  integrator-section enable, every active cycle
cic_clr  out  1  one-cycle synchronous clear to CIC state
out_valid  out  1  CIC output holds settled data
busy  out  1  state != IDLE
underrun  out  1  one-cycle pulse on zero-stuffed input period
underrun_cnt  out  UCNT_W  saturating underrun count

Behaviour:
- Reset (reset=0, async): state=IDLE, phase=0, ratio_q=2, all outputs 0, underrun_cnt=0.
- States: IDLE, FILL, RUN, FLUSH. busy=1 in all but IDLE.
- ratio_q: latched on IDLE->FILL; ratio<2 clamps to 2. Mid-run ratio changes ignored.
- phase: 0 in IDLE; in other states increments each cycle, wraps ratio_q-1 -> 0. First active cycle has phase=0.
- cic_in_stb = busy && phase==0 (combinational from registers). cic_out_stb = busy.
- s_ready = cic_in_stb && state in {FILL, RUN}; never high in IDLE/FLUSH.
- On cic_in_stb in FILL/RUN: s_valid=1 -> cic_in <= s_data. s_valid=0 -> cic_in <= 0, underrun pulses next cycle, underrun_cnt += 1 (saturates at all-ones). cic_in updates one cycle after strobe.
- In FLUSH, every strobe loads cic_in <= 0; no underrun counted.
- IDLE: enable=1 -> FILL next cycle, cic_clr pulses in that same transition cycle (CIC cleared before first strobe). Otherwise stay.
- FILL: count NUM_STAGES+2 input strobes. On the last one go to RUN; out_valid=1 from first RUN cycle. enable=0 during FILL -> FLUSH with fill count discarded; out_valid stays 0.
- RUN: out_valid=1. enable=0 -> FLUSH at the next phase==0 boundary: finish the current input period, and no strobe is lost or duplicated.
- FLUSH: emit NUM_STAGES+2 zero strobes (phase continues), out_valid holds its prior value. Then one cycle with cic_clr=1, out_valid=0 and state->IDLE; phase reset to 0.
- enable reasserted during FLUSH: ignored; the flush completes, and IDLE sees enable=1 and restarts on the following cycle.
- underrun_cnt clears only on reset.
- Reset asserted mid-operation: immediate return to reset values. No flush, and the CIC is cleared by its own reset.

Test Plan:
- ratio=4, enable=1 at cycle 0, s_valid=1 constant -> cic_clr at cycle 0; cic_in_stb/s_ready at cycles 1,5,9,...; out_valid rises at cycle 22 (after 6th strobe at cycle 21); cic_in mirrors accepted samples one cycle after each strobe.
- ratio=4, RUN, s_valid=0 for 3 consecutive strobes -> cic_in=0 for those periods, 3 underrun pulses, underrun_cnt=3; no phase slip.
- ratio=8, RUN, enable drop at phase 3 -> strobes continue on 8-cycle grid, FLUSH gives 6 zero strobes with s_ready=0, then cic_clr and out_valid=0 in the same cycle, busy=0 next cycle.
- ratio=0 and ratio=1 at start -> strobes every 2 cycles; change ratio to 10 mid-RUN -> period stays 2.
- Force 300 underruns with UCNT_W=8 -> underrun_cnt saturates at 255.
- Assert reset mid-FLUSH and mid-RUN -> all outputs 0 asynchronously; after release with enable=1, clean restart beginning with cic_clr.
